dt_classifier_seq: RTL and testbench



---
 rtl/dt_pkg.sv | 64 ++++++
 rtl/dt_node_eval.sv | 60 ++++++
 rtl/dt_classifier_seq.sv | 165 ++++++++++++++++
 tb/tb_dt_classifier_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared widths, node-word layout, node helpers and FSM states for the decision-tree classifier.
// Latency: none (declarations only).
// Backpressure: n/a.
package dt_pkg;

    localparam int FEAT_W    = 10;
    localparam int N_FEAT    = 3;
    localparam int N_CLASS   = 3;
    localparam int N_NODES   = 16;
    localparam int MAX_DEPTH = 8;

    localparam int FSEL_W  = $clog2(N_FEAT);
    localparam int IDX_W   = $clog2(N_NODES);
    localparam int CLS_W   = $clog2(N_CLASS);
    localparam int DEPTH_W = $clog2(MAX_DEPTH);
    localparam int FVEC_W  = N_FEAT * FEAT_W;

    // Node word field offsets, LSB first
    localparam int LEAF_OFS  = 0;
    localparam int FSEL_OFS  = LEAF_OFS + 1;
    localparam int THR_OFS   = FSEL_OFS + FSEL_W;
    localparam int LEFT_OFS  = THR_OFS + FEAT_W;
    localparam int RIGHT_OFS = LEFT_OFS + IDX_W;
    localparam int CLS_OFS   = RIGHT_OFS + IDX_W;
    localparam int NODE_W    = CLS_OFS + CLS_W;

    // Declared MSB first so the packed layout equals the LSB-first field order above
    typedef struct packed {
        logic [CLS_W-1:0]  cls;
        logic [IDX_W-1:0]  right;
        logic [IDX_W-1:0]  left;
        logic [FEAT_W-1:0] thresh;
        logic [FSEL_W-1:0] feat_sel;
        logic              is_leaf;
    } node_t;

    // Default table entry: a leaf with every other field zero, i.e. "class 0"
    localparam logic [NODE_W-1:0] NODE_RESET = NODE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic node_t unpack_node(input logic [NODE_W-1:0] word);
        return node_t'(word);
    endfunction

    // Builds a node word from plain integers; out-of-range values are truncated to field width
    function automatic logic [NODE_W-1:0] make_node(input logic is_leaf, input int feat_sel,
                                                    input int thresh, input int left,
                                                    input int right, input int cls);
        node_t n;
        n.is_leaf  = is_leaf;
        n.feat_sel = FSEL_W'(feat_sel);
        n.thresh   = FEAT_W'(thresh);
        n.left     = IDX_W'(left);
        n.right    = IDX_W'(right);
        n.cls      = CLS_W'(cls);
        return n;
    endfunction

endpackage

// File: rtl/dt_node_eval.sv
// Evaluates one tree node: unpack, feature select, unsigned compare, next index / leaf / fault.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module dt_node_eval
    import dt_pkg::*;
(
    input  logic [NODE_W-1:0] node_word,
    input  logic [FVEC_W-1:0] feat,
    output logic              leaf,
    output logic [IDX_W-1:0]  next_idx,
    output logic [CLS_W-1:0]  cls,
    output logic              bad
);

    node_t             n;
    logic [FEAT_W-1:0] fval;
    logic              go_left;
    logic              fsel_bad;
    logic              child_bad;
    logic              cls_bad;

    assign n = unpack_node(node_word);

    // Feature mux; an out-of-range selector yields zero and is flagged separately
    always_comb begin
        fval = '0;
        for (int k = 0; k < N_FEAT; k++) begin
            if (n.feat_sel == FSEL_W'(k)) begin
                fval = feat[k*FEAT_W +: FEAT_W];
            end
        end
    end

    assign go_left  = (fval <= n.thresh);
    assign next_idx = go_left ? n.left : n.right;
    assign leaf     = n.is_leaf;
    assign cls      = n.cls;

    // Range checks only exist when the field can encode values beyond the legal range
    generate
        if (N_FEAT < (1 << FSEL_W)) begin : g_fsel_chk
            assign fsel_bad = (n.feat_sel >= FSEL_W'(N_FEAT));
        end else begin : g_fsel_full
            assign fsel_bad = 1'b0;
        end
        if (N_NODES < (1 << IDX_W)) begin : g_idx_chk
            assign child_bad = (next_idx >= IDX_W'(N_NODES));
        end else begin : g_idx_full
            assign child_bad = 1'b0;
        end
        if (N_CLASS < (1 << CLS_W)) begin : g_cls_chk
            assign cls_bad = (n.cls >= CLS_W'(N_CLASS));
        end else begin : g_cls_full
            assign cls_bad = 1'b0;
        end
    endgenerate

    assign bad = n.is_leaf ? cls_bad : (fsel_bad | child_bad);

endmodule

// File: rtl/dt_classifier_seq.sv
// Table-driven decision-tree classifier: one feature vector per transaction, one node per cycle.
// Latency: vector accepted at edge t, leaf at depth d -> out_valid sampled high from edge t+2+d.
// Backpressure: result held in DONE until out_ready; in_ready low and table writes dropped meanwhile.
module dt_classifier_seq
    import dt_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [FVEC_W-1:0]  feat_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N_CLASS-1:0] decision,
    output logic [CLS_W-1:0]   class_idx,
    output logic               err,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [NODE_W-1:0]  cfg_wdata,
    output logic               cfg_busy
);

    state_t             state_q;
    state_t             state_d;
    logic [NODE_W-1:0]  node_tbl [N_NODES];
    logic [FVEC_W-1:0]  feat_q;
    logic [IDX_W-1:0]   cur_q;
    logic [DEPTH_W-1:0] depth_q;
    logic [N_CLASS-1:0] decision_q;
    logic [CLS_W-1:0]   class_idx_q;
    logic               err_q;

    logic               accept;
    logic               step;
    logic               finish;
    logic               fin_err;
    logic               depth_last;
    logic               addr_ok;
    logic               tbl_we;
    logic [NODE_W-1:0]  cur_node;
    logic               ev_leaf;
    logic               ev_bad;
    logic [IDX_W-1:0]   ev_next;
    logic [CLS_W-1:0]   ev_cls;

    assign cur_node = node_tbl[cur_q];

    dt_node_eval u_node_eval (
        .node_word (cur_node),
        .feat      (feat_q),
        .leaf      (ev_leaf),
        .next_idx  (ev_next),
        .cls       (ev_cls),
        .bad       (ev_bad)
    );

    assign depth_last = ((32'(depth_q) + 1) == MAX_DEPTH);

    generate
        if (N_NODES < (1 << IDX_W)) begin : g_addr_chk
            assign addr_ok = (cfg_addr < IDX_W'(N_NODES));
        end else begin : g_addr_full
            assign addr_ok = 1'b1;
        end
    endgenerate

    // Writes land only in IDLE; a write coinciding with accept is seen by the walk's first read
    assign tbl_we = cfg_we && (state_q == ST_IDLE) && addr_ok;

    // Node table: reset to all-leaf class 0, written from the config port
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N_NODES; i++) begin
                node_tbl[i] <= NODE_RESET;
            end
        end else if (tbl_we) begin
            node_tbl[cfg_addr] <= cfg_wdata;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus accept/step/finish strobes for the datapath
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        fin_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                if (ev_bad) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                    state_d = ST_DONE;
                end else if (ev_leaf) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end else if (depth_last) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Walk datapath: capture features, advance the node pointer, latch the result
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            feat_q      <= '0;
            cur_q       <= '0;
            depth_q     <= '0;
            decision_q  <= '0;
            class_idx_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                feat_q  <= feat_in;
                cur_q   <= '0;
                depth_q <= '0;
            end
            if (step) begin
                cur_q   <= ev_next;
                depth_q <= depth_q + 1'b1;
            end
            if (finish) begin
                err_q       <= fin_err;
                decision_q  <= fin_err ? '0 : (N_CLASS'(1) << ev_cls);
                class_idx_q <= fin_err ? '0 : ev_cls;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign cfg_busy  = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign decision  = decision_q;
    assign class_idx = class_idx_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dt_classifier_seq.sv
// Self-checking bench for dt_classifier_seq against a list-walking reference tree.
// Latency: measured per transaction in cycles from the accept edge.
// Backpressure: exercises stalled DONE, coincident config/accept and mid-walk reset.
module tb_dt_classifier_seq;
    import dt_pkg::*;

    logic               CLK;
    logic               RST;
    logic [FVEC_W-1:0]  feat_in;
    logic               in_valid;
    logic               in_ready;
    logic [N_CLASS-1:0] decision;
    logic [CLS_W-1:0]   class_idx;
    logic               err;
    logic               out_valid;
    logic               out_ready;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_addr;
    logic [NODE_W-1:0]  cfg_wdata;
    logic               cfg_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference tree, one entry per node, plain integers
    bit m_leaf [N_NODES];
    int m_fsel [N_NODES];
    int m_thr  [N_NODES];
    int m_left [N_NODES];
    int m_right[N_NODES];
    int m_cls  [N_NODES];

    dt_classifier_seq dut (
        .CLK       (CLK),
        .RST       (RST),
        .feat_in   (feat_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .decision  (decision),
        .class_idx (class_idx),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_busy  (cfg_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int a = 0; a < N_NODES; a++) begin
            m_leaf[a] = 1'b1; m_fsel[a] = 0; m_thr[a] = 0;
            m_left[a] = 0;    m_right[a] = 0; m_cls[a] = 0;
        end
    endfunction

    function automatic logic [NODE_W-1:0] set_node(input int a, input bit lf, input int fs,
                                                    input int th, input int l, input int r,
                                                    input int c);
        m_leaf[a] = lf; m_fsel[a] = fs; m_thr[a] = th;
        m_left[a] = l;  m_right[a] = r; m_cls[a] = c;
        return make_node(lf, fs, th, l, r, c);
    endfunction

    // Walk the reference tree: at most MAX_DEPTH nodes are visited, any bad field aborts
    function automatic void predict(input int f0, input int f1, input int f2,
                                    output int cls, output bit e, output int lat);
        int f[3];
        int cur;
        int nxt;
        f[0] = f0; f[1] = f1; f[2] = f2;
        cur = 0; cls = 0; e = 1'b0; lat = 0;
        for (int d = 0; d < 64; d++) begin
            lat = 2 + d;
            if (m_leaf[cur]) begin
                e   = (m_cls[cur] >= N_CLASS);
                cls = e ? 0 : m_cls[cur];
                return;
            end
            if (m_fsel[cur] >= N_FEAT) begin
                e = 1'b1;
                return;
            end
            nxt = (f[m_fsel[cur]] <= m_thr[cur]) ? m_left[cur] : m_right[cur];
            if (nxt >= N_NODES || d + 1 >= MAX_DEPTH) begin
                e = 1'b1;
                return;
            end
            cur = nxt;
        end
    endfunction

    task automatic write_node(input int a, input bit lf, input int fs, input int th,
                              input int l, input int r, input int c);
        cfg_wdata = set_node(a, lf, fs, th, l, r, c);
        cfg_addr  = IDX_W'(a);
        cfg_we    = 1'b1;
        @(negedge CLK);
        cfg_we    = 1'b0;
    endtask

    // One transaction; optional DONE stall of 'hold' cycles and optional coincident table write
    task automatic classify(input string tag, input int f0, input int f1, input int f2,
                            input int hold, input int co_addr, input logic [NODE_W-1:0] co_word);
        int                 ecls;
        int                 elat;
        int                 k;
        bit                 eerr;
        bit                 stable;
        logic [N_CLASS-1:0] edec;
        logic [N_CLASS-1:0] d0;
        logic [CLS_W-1:0]   c0;
        logic               e0;
        predict(f0, f1, f2, ecls, eerr, elat);
        edec = eerr ? '0 : (N_CLASS'(1) << ecls);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        if (co_addr >= 0) begin
            cfg_addr  = IDX_W'(co_addr);
            cfg_wdata = co_word;
            cfg_we    = 1'b1;
        end
        feat_in  = {FEAT_W'(f2), FEAT_W'(f1), FEAT_W'(f0)};
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        feat_in  = FVEC_W'($urandom);
        k = 1;
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge CLK);
            k++;
        end
        check({tag, ".latency"}, 32'(k), 32'(elat));
        check({tag, ".decision"}, 32'(decision), 32'(edec));
        check({tag, ".class_idx"}, 32'(class_idx), 32'(eerr ? 0 : ecls));
        check({tag, ".err"}, 32'(err), 32'(eerr));
        if (hold > 0) begin
            d0 = decision; c0 = class_idx; e0 = err;
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                cfg_addr  = IDX_W'(i);
                cfg_wdata = make_node(1'b1, 0, 0, 0, 0, 2);
                cfg_we    = 1'b1;
                @(negedge CLK);
                if (out_valid !== 1'b1 || decision !== d0 || class_idx !== c0 || err !== e0 ||
                    in_ready !== 1'b0 || cfg_busy !== 1'b1) stable = 1'b0;
            end
            cfg_we = 1'b0;
            check({tag, ".stall_stable"}, 32'(stable), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check({tag, ".idle_after"}, 32'({in_ready, out_valid, cfg_busy}), 32'b100);
    endtask

    task automatic rand_vec(input string tag);
        classify(tag, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                 0, -1, '0);
    endtask

    initial begin
        bit seen;
        RST = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; feat_in = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.decision", 32'(decision), 32'd0);
        check("rst.class_idx", 32'(class_idx), 32'd0);
        check("rst.cfg_busy", 32'(cfg_busy), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        rand_vec("unprogrammed");

        write_node(0, 1'b0, 0, 367, 1, 8, 0);
        write_node(1, 1'b0, 0, 287, 2, 3, 0);
        write_node(2, 1'b0, 1, 655, 4, 5, 0);
        write_node(3, 1'b0, 2, 639, 6, 7, 0);
        write_node(4, 1'b1, 0, 0, 0, 0, 0);
        write_node(5, 1'b1, 0, 0, 0, 0, 2);
        write_node(6, 1'b1, 0, 0, 0, 0, 2);
        write_node(7, 1'b1, 0, 0, 0, 0, 1);
        write_node(8, 1'b1, 0, 0, 0, 0, 1);
        classify("v100_500_0", 100, 500, 0, 0, -1, '0);
        classify("v400_0_0", 400, 0, 0, 0, -1, '0);
        classify("v367_656_0", 367, 656, 0, 0, -1, '0);
        classify("v300_0_640", 300, 0, 640, 0, -1, '0);
        classify("v300_0_639", 300, 0, 639, 0, -1, '0);

        write_node(0, 1'b0, 0, 0, 0, 0, 0);
        classify("err_depth", 5, 5, 5, 0, -1, '0);
        write_node(0, 1'b0, 3, 0, 1, 1, 0);
        classify("err_fsel", 5, 5, 5, 0, -1, '0);
        write_node(0, 1'b1, 0, 0, 0, 0, 3);
        classify("err_cls", 5, 5, 5, 0, -1, '0);

        write_node(0, 1'b0, 0, 367, 1, 8, 0);
        classify("stall", 100, 500, 0, 10, -1, '0);
        classify("after_stall", 100, 500, 0, 0, -1, '0);

        classify("coincident", 5, 5, 5, 0, 0, set_node(0, 1'b1, 0, 0, 0, 0, 2));

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < N_NODES; a++) begin
                write_node(a, ($urandom_range(0, 99) < 35),
                           ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                           $urandom_range(0, 1023), $urandom_range(0, 15), $urandom_range(0, 15),
                           ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2));
            end
            for (int v = 0; v < 8; v++) rand_vec("random");
        end

        write_node(0, 1'b0, 0, 0, 0, 0, 0);
        feat_in  = FVEC_W'($urandom);
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        check("midwalk.busy", 32'(cfg_busy), 32'd1);
        RST = 1'b0;
        #1;
        check("midwalk.rst_out_valid", 32'(out_valid), 32'd0);
        check("midwalk.rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("midwalk.no_out_valid", 32'(seen), 32'd0);
        rand_vec("after_midwalk_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
